data_mem_ctrl: RTL and testbench

Wait-state data memory controller. It sits directly downstream of the multi-cycle CPU's MEM stage and serves its lw/sw accesses. It holds a word-addressed RAM and completes each access after a programmable number of wait cycles, using a req/ready handshake so the CPU can stall in MEM. It also flags misaligned and out-of-range addresses.

---
 rtl/data_mem_ctrl_if.sv | 25 ++
 rtl/data_mem_ctrl.sv | 104 ++++++++++
 tb/tb_data_mem_ctrl.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/data_mem_ctrl_if.sv
// CPU-side request/response bundle for the wait-state data memory controller.
// The master drives the request; the slave returns data, completion and status.
interface data_mem_ctrl_if #(
  parameter int ADDR_LEN = 32,
  parameter int DATA_LEN = 32
);
  logic                req;
  logic                we;
  logic [ADDR_LEN-1:0] addr;
  logic [DATA_LEN-1:0] wdata;
  logic [DATA_LEN-1:0] rdata;
  logic                ready;
  logic                err;
  logic                busy;

  modport master (
    output req, we, addr, wdata,
    input  rdata, ready, err, busy
  );

  modport slave (
    input  req, we, addr, wdata,
    output rdata, ready, err, busy
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// Word-addressed data RAM serving lw/sw from the MEM stage, completing each
// access after a programmable number of wait cycles, with fault detection.
//
// state    | meaning
// S_IDLE   | waiting for req; latches the request on acceptance
// S_WAIT   | wait-state down-counter running until terminal count 0
// S_ACCESS | array read or write of the latched word index
// S_DONE   | ready pulse; err reflects the latched fault
module data_mem_ctrl #(
  parameter int ADDR_LEN    = 32,
  parameter int DATA_LEN    = 32,
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic          clk,
  input  logic          rst,
  data_mem_ctrl_if.slave bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic [DEPTH_LOG2-1:0] idx_q, idx_d;
  logic [DATA_LEN-1:0]   wdata_q, wdata_d;
  logic [DATA_LEN-1:0]   rdata_q, rdata_d;
  logic                  fault_q, fault_d;
  logic [DATA_LEN-1:0]   mem_q [DEPTH];
  logic                  mem_wr;
  logic                  addr_bad;

  // Fault is resolved at acceptance so only the word index needs latching.
  assign addr_bad = (bus.addr[1:0] != 2'b00) ||
                    (bus.addr[ADDR_LEN-1:DEPTH_LOG2+2] != '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    fault_d = fault_q;
    mem_wr  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.req) begin
          we_d    = bus.we;
          idx_d   = bus.addr[DEPTH_LOG2+1:2];
          wdata_d = bus.wdata;
          fault_d = addr_bad;
          if (addr_bad) begin
            state_d = S_DONE;
          end else if (WAIT_CYCLES == 0) begin
            state_d = S_ACCESS;
          end else begin
            cnt_d   = 4'(WAIT_CYCLES - 1);
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_ACCESS;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_ACCESS: begin
        if (we_q) mem_wr  = 1'b1;
        else      rdata_d = mem_q[idx_q];
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      fault_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      fault_q <= fault_d;
      if (mem_wr) mem_q[idx_q] <= wdata_q;
    end
  end

  assign bus.rdata = rdata_q;
  assign bus.ready = (state_q == S_DONE);
  assign bus.err   = (state_q == S_DONE) && fault_q;
  assign bus.busy  = (state_q != S_IDLE);
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: one instance with two wait cycles and one
// with none, driven from a vector table plus hand-written corner sequences.
module tb_data_mem_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        sel;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;

  always #5 clk = ~clk;

  data_mem_ctrl_if #(.ADDR_LEN(32), .DATA_LEN(32)) b0 ();
  data_mem_ctrl_if #(.ADDR_LEN(32), .DATA_LEN(32)) b1 ();

  assign b0.req   = req && !sel;
  assign b0.we    = we;
  assign b0.addr  = addr;
  assign b0.wdata = wdata;
  assign b1.req   = req && sel;
  assign b1.we    = we;
  assign b1.addr  = addr;
  assign b1.wdata = wdata;

  data_mem_ctrl #(.ADDR_LEN(32), .DATA_LEN(32), .DEPTH_LOG2(10), .WAIT_CYCLES(2))
    dut0 (.clk(clk), .rst(rst), .bus(b0));
  data_mem_ctrl #(.ADDR_LEN(32), .DATA_LEN(32), .DEPTH_LOG2(10), .WAIT_CYCLES(0))
    dut1 (.clk(clk), .rst(rst), .bus(b1));

  logic [31:0] rdata_s;
  logic        ready_s, err_s, busy_s;
  assign rdata_s = sel ? b1.rdata : b0.rdata;
  assign ready_s = sel ? b1.ready : b0.ready;
  assign err_s   = sel ? b1.err   : b0.err;
  assign busy_s  = sel ? b1.busy  : b0.busy;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        sel;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic        err;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic s, input logic w, input logic [31:0] a,
                     input logic [31:0] d, input int l, input logic e,
                     input logic [31:0] r);
    vec_t v;
    v.sel = s; v.we = w; v.addr = a; v.wdata = d;
    v.lat = l; v.err = e; v.rdata = r;
    vecs.push_back(v);
  endtask

  // One access: present on a negedge, accepted on the next posedge, then
  // count cycles to ready, sampling on negedges.
  task automatic run_access(input logic s, input logic w, input logic [31:0] a,
                            input logic [31:0] d, output int lat, output int busy_n,
                            output logic e, output logic [31:0] rd);
    @(negedge clk);
    sel = s; req = 1'b1; we = w; addr = a; wdata = d;
    lat = 0; busy_n = 0; e = 1'b0; rd = '0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      req = 1'b0;
      if (busy_s) busy_n++;
      if (ready_s) begin
        lat = n; e = err_s; rd = rdata_s;
        break;
      end
    end
  endtask

  initial begin
    int          lat, bn;
    logic        e;
    logic [31:0] rd;

    rst = 1'b1; sel = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;

    // dut0: WAIT_CYCLES=2
    add(0, 1, 32'h0000_0010, 32'hDEADBEEF, 4, 0, 32'h0000_0000);
    add(0, 0, 32'h0000_0010, 32'h0,        4, 0, 32'hDEADBEEF);
    add(0, 0, 32'h0000_0013, 32'h0,        1, 1, 32'hDEADBEEF);
    add(0, 0, 32'h0000_1000, 32'h0,        1, 1, 32'hDEADBEEF);
    add(0, 1, 32'h0000_0012, 32'h0000_0099, 1, 1, 32'hDEADBEEF);
    add(0, 0, 32'h0000_0010, 32'h0,        4, 0, 32'hDEADBEEF);
    add(0, 1, 32'h0000_0000, 32'h11111111, 4, 0, 32'hDEADBEEF);
    add(0, 1, 32'h0000_0FFC, 32'h22222222, 4, 0, 32'hDEADBEEF);
    add(0, 0, 32'h0000_0000, 32'h0,        4, 0, 32'h11111111);
    add(0, 0, 32'h0000_0FFC, 32'h0,        4, 0, 32'h22222222);
    add(0, 1, 32'h8000_0000, 32'hAAAAAAAA, 1, 1, 32'h22222222);
    add(0, 0, 32'h0000_0000, 32'h0,        4, 0, 32'h11111111);
    add(0, 1, 32'h0000_0040, 32'h12345678, 4, 0, 32'h11111111);
    // dut1: WAIT_CYCLES=0
    add(1, 1, 32'h0000_0008, 32'h0000_0007, 2, 0, 32'h0000_0000);
    add(1, 0, 32'h0000_0008, 32'h0,         2, 0, 32'h0000_0007);
    add(1, 0, 32'h0000_000A, 32'h0,         1, 1, 32'h0000_0007);

    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      sel = (d == 1);
      #1;
      chk("reset_busy",  {31'b0, busy_s},  32'h0);
      chk("reset_ready", {31'b0, ready_s}, 32'h0);
      chk("reset_err",   {31'b0, err_s},   32'h0);
      chk("reset_rdata", rdata_s,          32'h0);
    end
    sel = 1'b0;
    rst = 1'b0;

    foreach (vecs[i]) begin
      run_access(vecs[i].sel, vecs[i].we, vecs[i].addr, vecs[i].wdata, lat, bn, e, rd);
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      chk($sformatf("v%0d_busy_cycles", i), 32'(bn), 32'(vecs[i].lat));
      chk($sformatf("v%0d_err", i), {31'b0, e}, {31'b0, vecs[i].err});
      chk($sformatf("v%0d_rdata", i), rd, vecs[i].rdata);
    end

    // Held req with changing inputs during the access: latched load of 0x40 wins.
    @(negedge clk);
    sel = 1'b0; req = 1'b1; we = 1'b0; addr = 32'h40; wdata = '0;
    lat = 0; e = 1'b0; rd = '0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      we = 1'b1; wdata = 32'hFFFF_FFFF;
      addr = (n % 2 == 1) ? 32'h44 : 32'h13;
      if (ready_s) begin
        lat = n; e = err_s; rd = rdata_s;
        break;
      end
    end
    chk("hold_latency", 32'(lat), 32'd4);
    chk("hold_err", {31'b0, e}, 32'h0);
    chk("hold_rdata", rd, 32'h12345678);
    addr = 32'h44; we = 1'b0; wdata = '0;
    @(negedge clk);
    chk("idle_after_done_busy",  {31'b0, busy_s},  32'h0);
    chk("idle_after_done_ready", {31'b0, ready_s}, 32'h0);
    @(negedge clk);
    chk("second_accept_busy", {31'b0, busy_s}, 32'h1);
    req = 1'b0;
    lat = 0; rd = 32'hFFFF_FFFF;
    for (int n = 2; n <= 20; n++) begin
      @(negedge clk);
      if (ready_s) begin
        lat = n; rd = rdata_s;
        break;
      end
    end
    chk("second_latency", 32'(lat), 32'd4);
    chk("second_rdata_0x44", rd, 32'h0);

    // Reset sampled on the ACCESS edge of a store to 0x20.
    @(negedge clk);
    sel = 1'b0; req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'h5A5A5A5A;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_busy",  {31'b0, busy_s},  32'h1);
    chk("pre_rst_ready", {31'b0, ready_s}, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_busy",  {31'b0, busy_s},  32'h0);
    chk("post_rst_ready", {31'b0, ready_s}, 32'h0);
    chk("post_rst_err",   {31'b0, err_s},   32'h0);
    chk("post_rst_rdata", rdata_s,          32'h0);
    rst = 1'b0;
    run_access(0, 0, 32'h20, 32'h0, lat, bn, e, rd);
    chk("abandoned_store_latency", 32'(lat), 32'd4);
    chk("abandoned_store_err", {31'b0, e}, 32'h0);
    chk("abandoned_store_rdata", rd, 32'h0);
    run_access(0, 0, 32'h0, 32'h0, lat, bn, e, rd);
    chk("ram_cleared_rdata", rd, 32'h0);
    run_access(1, 0, 32'h8, 32'h0, lat, bn, e, rd);
    chk("ram_cleared_w0_latency", 32'(lat), 32'd2);
    chk("ram_cleared_w0_rdata", rd, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
